rtc_apb_alarm: RTL and testbench



---
 rtl/rtc_apb_alarm_pkg.sv | 56 +++++
 rtl/rtc_apb_alarm_if.sv | 24 ++
 rtl/rtc_alarm_ch.sv | 58 +++++
 rtl/rtc_apb_alarm.sv | 198 +++++++++++++++++++
 tb/tb_rtc_apb_alarm.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_apb_alarm_pkg.sv
// rtl/rtc_apb_alarm_pkg.sv - register map, field indices and bus helpers for the alarm RTC
package rtc_apb_alarm_pkg;

   // Byte offsets of the global registers
   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_PRESC    = 8'h04;
   localparam logic [7:0] OFF_CNT      = 8'h08;
   localparam logic [7:0] OFF_IRQ_STAT = 8'h0C;
   localparam logic [7:0] OFF_IRQ_EN   = 8'h10;

   // Channel window: channel i lives at CH_BASE + i*CH_STRIDE
   localparam logic [7:0] OFF_CH_BASE  = 8'h20;
   localparam int         CH_STRIDE    = 16;

   // Word index inside one channel window
   localparam logic [1:0] CH_CMP       = 2'd0;
   localparam logic [1:0] CH_PERIOD    = 2'd1;
   localparam logic [1:0] CH_CFG       = 2'd2;

   // Field bit positions
   localparam int CTRL_EN  = 0;
   localparam int CFG_ARM  = 0;
   localparam int CFG_AUTO = 1;

   // Which register the current APB address decodes to
   typedef enum logic [2:0] {
      REG_NONE,
      REG_CTRL,
      REG_PRESC,
      REG_CNT,
      REG_STAT,
      REG_IRQEN,
      REG_CH
   } reg_sel_e;

   // Replace the bytes of old_val selected by strb with the matching bytes of wdata
   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

   // Expand byte strobes to a bit mask
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = {8{strb[b]}};
      end
      return res;
   endfunction

endpackage

// File: rtl/rtc_apb_alarm_if.sv
// rtl/rtc_apb_alarm_if.sv - APB bundle used by sim tops to drive the alarm RTC
interface rtc_apb_alarm_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic              pready;
   logic [31:0]       prdata;
   logic              pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/rtc_alarm_ch.sv
// rtl/rtc_alarm_ch.sv - one alarm compare channel with one-shot / auto-reload behaviour
module rtc_alarm_ch
   import rtc_apb_alarm_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [CNT_W-1:0] cnt_next,
   input  logic             wr_cmp,
   input  logic             wr_period,
   input  logic             wr_cfg,
   input  logic [CNT_W-1:0] wr_value,
   input  logic [1:0]       cfg_value,
   output logic [CNT_W-1:0] cmp,
   output logic [CNT_W-1:0] period,
   output logic             arm,
   output logic             auto_rl,
   output logic             match
);

   // Fire when the counter is about to enter the compare value
   always_comb begin
      match = tick && arm && (cnt_next == cmp);
   end

   // Compare and period registers; a CPU write beats the auto-reload step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp    <= '0;
         period <= '0;
      end else begin
         if (wr_cmp) begin
            cmp <= wr_value;
         end else if (match && auto_rl) begin
            cmp <= cmp + period;
         end
         if (wr_period) begin
            period <= wr_value;
         end
      end
   end

   // Arm/auto flags; one-shot channels disarm themselves on a match unless the CPU writes CFG
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm     <= 1'b0;
         auto_rl <= 1'b0;
      end else if (wr_cfg) begin
         arm     <= cfg_value[CFG_ARM];
         auto_rl <= cfg_value[CFG_AUTO];
      end else if (match && !auto_rl) begin
         arm     <= 1'b0;
      end
   end

endmodule

// File: rtl/rtc_apb_alarm.sv
// rtl/rtc_apb_alarm.sv - prescaled RTC counter with N compare alarms behind an APB slave
module rtc_apb_alarm
   import rtc_apb_alarm_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PRESC_W    = 16,
   parameter int N_ALARM    = 4,
   parameter int APB_ADDR_W = 12
) (
   input  logic                  pclk,
   input  logic                  prst_n,
   input  logic [APB_ADDR_W-1:0] s_apb_paddr,
   input  logic                  s_apb_psel,
   input  logic                  s_apb_penable,
   input  logic                  s_apb_pwrite,
   input  logic [31:0]           s_apb_pwdata,
   input  logic [3:0]            s_apb_pstrb,
   output logic                  s_apb_pready,
   output logic [31:0]           s_apb_prdata,
   output logic                  s_apb_pslverr,
   output logic                  irq
);

   logic                 en;
   logic [PRESC_W-1:0]   presc;
   logic [PRESC_W-1:0]   pc;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_next;
   logic [N_ALARM-1:0]   irq_stat;
   logic [N_ALARM-1:0]   irq_en;
   logic [N_ALARM-1:0]   match_vec;
   logic [N_ALARM-1:0]   ch_arm;
   logic [N_ALARM-1:0]   ch_auto;
   logic [CNT_W-1:0]     ch_cmp    [N_ALARM];
   logic [CNT_W-1:0]     ch_period [N_ALARM];

   reg_sel_e             sel;
   logic [2:0]           ch_idx;
   logic [1:0]           ch_word;
   logic [7:0]           addr_lo;
   logic                 addr_hi_zero;
   logic                 access;
   logic                 wr_en;
   logic                 wr_ch;
   logic                 cnt_wr;
   logic                 presc_wr;
   logic                 tick;
   logic                 tick_eval;
   logic [31:0]          reg_rd;
   logic [31:0]          wmerge;
   logic [31:0]          w1c;
   logic [N_ALARM-1:0]   stat_clr;
   logic                 unused_ok;

   assign addr_lo      = s_apb_paddr[7:0];
   assign addr_hi_zero = ((s_apb_paddr >> 8) == '0);
   assign access       = s_apb_psel && s_apb_penable;

   // Address decode: global registers, then the channel window bounded by N_ALARM
   always_comb begin
      sel     = REG_NONE;
      ch_idx  = '0;
      ch_word = '0;
      if (addr_hi_zero) begin
         if (addr_lo[7:2] == OFF_CTRL[7:2]) begin
            sel = REG_CTRL;
         end else if (addr_lo[7:2] == OFF_PRESC[7:2]) begin
            sel = REG_PRESC;
         end else if (addr_lo[7:2] == OFF_CNT[7:2]) begin
            sel = REG_CNT;
         end else if (addr_lo[7:2] == OFF_IRQ_STAT[7:2]) begin
            sel = REG_STAT;
         end else if (addr_lo[7:2] == OFF_IRQ_EN[7:2]) begin
            sel = REG_IRQEN;
         end else if (addr_lo >= OFF_CH_BASE &&
                      addr_lo < OFF_CH_BASE + 8'(N_ALARM * CH_STRIDE) &&
                      addr_lo[3:2] != 2'd3) begin
            sel     = REG_CH;
            ch_idx  = 3'(addr_lo[7:4] - 4'd2);
            ch_word = addr_lo[3:2];
         end
      end
   end

   // Read mux of the addressed register, zero-extended to the bus width
   always_comb begin
      reg_rd = '0;
      case (sel)
         REG_CTRL:  reg_rd[CTRL_EN] = en;
         REG_PRESC: reg_rd = 32'(presc);
         REG_CNT:   reg_rd = 32'(cnt);
         REG_STAT:  reg_rd = 32'(irq_stat);
         REG_IRQEN: reg_rd = 32'(irq_en);
         REG_CH: begin
            for (int i = 0; i < N_ALARM; i++) begin
               if (ch_idx == 3'(i)) begin
                  case (ch_word)
                     CH_CMP:    reg_rd = 32'(ch_cmp[i]);
                     CH_PERIOD: reg_rd = 32'(ch_period[i]);
                     default:   reg_rd = 32'({ch_auto[i], ch_arm[i]});
                  endcase
               end
            end
         end
         default: reg_rd = '0;
      endcase
   end

   assign s_apb_pready  = 1'b1;
   assign s_apb_prdata  = access ? reg_rd : 32'd0;
   assign s_apb_pslverr = access && (sel == REG_NONE);

   assign wr_en    = access && s_apb_pwrite && (sel != REG_NONE);
   assign wr_ch    = wr_en && (sel == REG_CH);
   assign cnt_wr   = wr_en && (sel == REG_CNT);
   assign presc_wr = wr_en && (sel == REG_PRESC);
   assign wmerge   = strb_merge(reg_rd, s_apb_pwdata, s_apb_pstrb);
   assign w1c      = s_apb_pwdata & strb_mask(s_apb_pstrb);
   assign stat_clr = (wr_en && sel == REG_STAT) ? w1c[N_ALARM-1:0] : '0;

   assign tick      = en && (pc == presc);
   assign tick_eval = tick && !cnt_wr;
   assign cnt_next  = cnt + CNT_W'(1);

   assign unused_ok = ^{wmerge, w1c, s_apb_paddr[1:0]};

   // Plain control registers: enable, prescaler divisor, interrupt enables
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         en     <= 1'b0;
         presc  <= '0;
         irq_en <= '0;
      end else begin
         if (wr_en && sel == REG_CTRL)  en     <= wmerge[CTRL_EN];
         if (presc_wr)                  presc  <= wmerge[PRESC_W-1:0];
         if (wr_en && sel == REG_IRQEN) irq_en <= wmerge[N_ALARM-1:0];
      end
   end

   // Prescaler and counter; a CNT or PRESC write restarts the prescaler phase
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         pc  <= '0;
         cnt <= '0;
      end else begin
         if (presc_wr || cnt_wr) begin
            pc <= '0;
         end else if (en) begin
            pc <= tick ? '0 : pc + PRESC_W'(1);
         end
         if (cnt_wr) begin
            cnt <= wmerge[CNT_W-1:0];
         end else if (tick) begin
            cnt <= cnt_next;
         end
      end
   end

   // Interrupt status: W1C clear, hardware set wins on the same edge
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         irq_stat <= '0;
      end else begin
         irq_stat <= (irq_stat & ~stat_clr) | match_vec;
      end
   end

   // Registered interrupt output
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(irq_stat & irq_en);
      end
   end

   for (genvar g = 0; g < N_ALARM; g++) begin : g_ch
      rtc_alarm_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (pclk),
         .rst_n     (prst_n),
         .tick      (tick_eval),
         .cnt_next  (cnt_next),
         .wr_cmp    (wr_ch && ch_idx == 3'(g) && ch_word == CH_CMP),
         .wr_period (wr_ch && ch_idx == 3'(g) && ch_word == CH_PERIOD),
         .wr_cfg    (wr_ch && ch_idx == 3'(g) && ch_word == CH_CFG),
         .wr_value  (wmerge[CNT_W-1:0]),
         .cfg_value (wmerge[1:0]),
         .cmp       (ch_cmp[g]),
         .period    (ch_period[g]),
         .arm       (ch_arm[g]),
         .auto_rl   (ch_auto[g]),
         .match     (match_vec[g])
      );
   end

endmodule

// File: tb/tb_rtc_apb_alarm.sv
// tb/tb_rtc_apb_alarm.sv - self-checking bench for the alarm RTC
module tb_rtc_apb_alarm;

   localparam int CNT_W   = 16;
   localparam int PRESC_W = 8;
   localparam int N_ALARM = 3;
   localparam int AW      = 12;

   logic        pclk   = 1'b0;
   logic        prst_n = 1'b0;
   logic        irq;
   int          total  = 0;
   int          bad    = 0;
   logic [32:0] exp_q [$];
   logic [32:0] got;
   logic [32:0] want;
   logic [31:0] rd;
   logic        re;
   logic        we;

   rtc_apb_alarm_if #(.ADDR_W(AW)) bus ();

   always #5 pclk = ~pclk;

   rtc_apb_alarm #(
      .CNT_W      (CNT_W),
      .PRESC_W    (PRESC_W),
      .N_ALARM    (N_ALARM),
      .APB_ADDR_W (AW)
   ) dut (
      .pclk          (pclk),
      .prst_n        (prst_n),
      .s_apb_paddr   (bus.paddr),
      .s_apb_psel    (bus.psel),
      .s_apb_penable (bus.penable),
      .s_apb_pwrite  (bus.pwrite),
      .s_apb_pwdata  (bus.pwdata),
      .s_apb_pstrb   (bus.pstrb),
      .s_apb_pready  (bus.pready),
      .s_apb_prdata  (bus.prdata),
      .s_apb_pslverr (bus.pslverr),
      .irq           (irq)
   );

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic err);
      @(posedge pclk); #1;
      bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
      bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      @(negedge pclk);
      err = bus.pslverr;
      @(posedge pclk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      @(posedge pclk); #1;
      bus.paddr = a; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      @(negedge pclk);
      d   = bus.prdata;
      err = bus.pslverr;
      @(posedge pclk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] addrs [14];
      addrs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'h024,
                12'h028, 12'h030, 12'h034, 12'h038, 12'h040, 12'h044, 12'h048};
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      total++;
      if ({irq, bus.pslverr, bus.prdata} !== 34'd0) begin
         bad++;
         $display("FAIL reset_outputs got irq=%b err=%b data=%h want 0", irq, bus.pslverr, bus.prdata);
      end
      prst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         exp_q.push_back(33'd0);
         apb_read(addrs[i], rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_read a=%h got=%h want=%h", addrs[i], got, want);
         end
      end
      exp_q.push_back({1'b1, 32'd0});
      apb_read(12'h0FC, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin
         bad++;
         $display("FAIL unmapped_0fc got=%h want=%h", got, want);
      end
   endtask

   task automatic test_counter();
      apb_write(12'h004, 32'd3, 4'hF, we);
      apb_write(12'h008, 32'd0, 4'hF, we);
      apb_write(12'h000, 32'd1, 4'hF, we);
      repeat (38) @(posedge pclk);
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back({1'b0, 32'((40 + 3 * n) / 4)});
         apb_read(12'h008, rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL counter_read n=%0d got=%h want=%h", n, got, want);
         end
      end
   endtask

   task automatic test_oneshot();
      logic [11:0] ra [3];
      apb_write(12'h000, 32'd0, 4'hF, we);
      apb_write(12'h004, 32'd0, 4'hF, we);
      apb_write(12'h008, 32'd0, 4'hF, we);
      apb_write(12'h020, 32'd5, 4'hF, we);
      apb_write(12'h028, 32'd1, 4'hF, we);
      apb_write(12'h010, 32'd1, 4'hF, we);
      apb_write(12'h000, 32'd1, 4'hF, we);
      repeat (5) @(posedge pclk);
      @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early got=%b want=0", irq); end
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq_rise got=%b want=1", irq); end
      apb_write(12'h000, 32'd0, 4'hF, we);
      ra = '{12'h00C, 12'h028, 12'h008};
      exp_q.push_back({1'b0, 32'd1});
      exp_q.push_back({1'b0, 32'd0});
      exp_q.push_back({1'b0, 32'd9});
      for (int i = 0; i < 3; i++) begin
         apb_read(ra[i], rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL oneshot_read a=%h got=%h want=%h", ra[i], got, want);
         end
      end
      apb_write(12'h00C, 32'd1, 4'hF, we);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b want=1", irq); end
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_fall got=%b want=0", irq); end
   endtask

   task automatic test_periodic();
      logic [11:0] ra [5];
      apb_write(12'h008, 32'd0, 4'hF, we);
      apb_write(12'h010, 32'd2, 4'hF, we);
      apb_write(12'h030, 32'd10, 4'hF, we);
      apb_write(12'h034, 32'd10, 4'hF, we);
      apb_write(12'h038, 32'd3, 4'hF, we);
      apb_write(12'h000, 32'd1, 4'hF, we);
      repeat (10) @(posedge pclk);
      @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL periodic_pre10 got=%b want=0", irq); end
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL periodic_hit10 got=%b want=1", irq); end
      apb_write(12'h00C, 32'd2, 4'hF, we);
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL periodic_clr1 got=%b want=0", irq); end
      repeat (2) @(posedge pclk);
      apb_write(12'h00C, 32'd2, 4'hF, we);
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL set_beats_w1c got=%b want=1", irq); end
      repeat (2) @(posedge pclk);
      apb_write(12'h00C, 32'd2, 4'hF, we);
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL periodic_clr2 got=%b want=0", irq); end
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL periodic_pre30 got=%b want=0", irq); end
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL periodic_hit30 got=%b want=1", irq); end
      apb_write(12'h000, 32'd0, 4'hF, we);
      ra = '{12'h030, 12'h034, 12'h038, 12'h00C, 12'h008};
      exp_q.push_back({1'b0, 32'd40});
      exp_q.push_back({1'b0, 32'd10});
      exp_q.push_back({1'b0, 32'd3});
      exp_q.push_back({1'b0, 32'd2});
      exp_q.push_back({1'b0, 32'd34});
      for (int i = 0; i < 5; i++) begin
         apb_read(ra[i], rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL periodic_read a=%h got=%h want=%h", ra[i], got, want);
         end
      end
   endtask

   task automatic test_wrap();
      logic [11:0] ra [3];
      apb_write(12'h00C, 32'd7, 4'hF, we);
      apb_write(12'h010, 32'd4, 4'hF, we);
      apb_write(12'h008, 32'hFFFE, 4'hF, we);
      apb_write(12'h040, 32'd1, 4'hF, we);
      apb_write(12'h048, 32'd1, 4'hF, we);
      apb_write(12'h000, 32'd1, 4'hF, we);
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL wrap_irq_early got=%b want=0", irq); end
      @(posedge pclk); #1;
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq_rise got=%b want=1", irq); end
      apb_write(12'h000, 32'd0, 4'hF, we);
      ra = '{12'h048, 12'h00C, 12'h008};
      exp_q.push_back({1'b0, 32'd0});
      exp_q.push_back({1'b0, 32'd4});
      exp_q.push_back({1'b0, 32'd5});
      for (int i = 0; i < 3; i++) begin
         apb_read(ra[i], rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL wrap_read a=%h got=%h want=%h", ra[i], got, want);
         end
      end
      apb_write(12'h004, 32'd3, 4'hF, we);
      apb_write(12'h008, 32'd0, 4'hF, we);
      apb_write(12'h000, 32'd1, 4'hF, we);
      repeat (5) @(posedge pclk);
      apb_write(12'h008, 32'h100, 4'hF, we);
      exp_q.push_back({1'b0, 32'h100});
      apb_read(12'h008, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL cnt_write_vs_tick got=%h want=%h", got, want); end
      apb_write(12'h008, 32'h200, 4'hF, we);
      exp_q.push_back({1'b0, 32'h200});
      exp_q.push_back({1'b0, 32'h201});
      for (int i = 0; i < 2; i++) begin
         apb_read(12'h008, rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL pc_restart i=%0d got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_bounds();
      apb_write(12'h000, 32'd0, 4'hF, we);
      apb_write(12'h050, 32'hFFFF_FFFF, 4'hF, we);
      total++;
      if (we !== 1'b1) begin bad++; $display("FAIL ch3_write_err got=%b want=1", we); end
      exp_q.push_back({1'b1, 32'd0});
      apb_read(12'h050, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL ch3_read got=%h want=%h", got, want); end
      exp_q.push_back({1'b1, 32'd0});
      apb_read(12'h02C, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL ch_hole_read got=%h want=%h", got, want); end
      exp_q.push_back({1'b0, 32'd5});
      apb_read(12'h020, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL cmp0_untouched got=%h want=%h", got, want); end
      apb_write(12'h020, 32'hFFFF_FFFF, 4'b0001, we);
      exp_q.push_back({1'b0, 32'h0000_00FF});
      apb_read(12'h020, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL pstrb_byte0 got=%h want=%h", got, want); end
      apb_write(12'h020, 32'h1234_5678, 4'b0000, we);
      exp_q.push_back({1'b0, 32'h0000_00FF});
      apb_read(12'h020, rd, re);
      got = {we, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL pstrb_zero got=%h want=%h", got, want); end
      apb_write(12'h008, 32'hFFFF_FFFF, 4'hF, we);
      exp_q.push_back({1'b0, 32'h0000_FFFF});
      apb_read(12'h008, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL cnt_width got=%h want=%h", got, want); end
      apb_write(12'h004, 32'h1234_5678, 4'hF, we);
      exp_q.push_back({1'b0, 32'h0000_0078});
      apb_read(12'h004, rd, re);
      got = {re, rd}; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL presc_width got=%h want=%h", got, want); end
   endtask

   task automatic test_async_reset();
      logic [11:0] ra [3];
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b want=1", irq); end
      @(negedge pclk); #2;
      prst_n = 1'b0;
      #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL async_irq_drop got=%b want=0", irq); end
      @(negedge pclk);
      prst_n = 1'b1;
      ra = '{12'h00C, 12'h000, 12'h020};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(33'd0);
         apb_read(ra[i], rd, re);
         got = {re, rd}; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL post_reset_read a=%h got=%h want=%h", ra[i], got, want);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_counter();
      test_oneshot();
      test_periodic();
      test_wrap();
      test_bounds();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
